// File: rtl/ram_sr_feeder.sv
// Stream-side writer for the ram_sr window buffer: turns a raster pixel stream into
// column pushes plus one row-shift per row, tracking position and window readiness.
module ram_sr_feeder #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int ROW_SHIFT  = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [7:0]                        pixel_in,
    input  logic                              pixel_valid,
    output logic                              pixel_ready,
    input  logic                              out_ready,
    output logic                              sr_enable,
    output logic                              sr_shift_row_up,
    output logic [7:0]                        column_shift_in,
    output logic [$clog2(IMG_WIDTH+1)-1:0]    col_count,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]   row_count,
    output logic                              window_valid,
    output logic                              busy,
    output logic                              frame_done
);

    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ROWSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            shup_q, shup_d;
    logic            wv_q, wv_d;
    logic            row_full_s;
    logic            accept_s;

    // A full row blocks further pixels until its row shift has been issued.
    assign row_full_s  = (pix_cnt_q == CW'(IMG_WIDTH));
    assign pixel_ready = (state_q == STREAM) && out_ready && !row_full_s;
    assign accept_s    = pixel_valid && pixel_ready;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        data_d    = data_q;
        en_d      = 1'b0;
        shup_d    = 1'b0;
        wv_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (row_full_s) begin
                    if (out_ready) begin
                        en_d      = 1'b1;
                        shup_d    = 1'b1;
                        row_d     = row_q + RW'(1);
                        col_d     = {CW{1'b0}};
                        pix_cnt_d = {CW{1'b0}};
                        state_d   = ROWSH;
                    end else begin
                        state_d = STREAM;
                    end
                end else if (accept_s) begin
                    en_d      = 1'b1;
                    data_d    = pixel_in;
                    col_d     = pix_cnt_q;
                    pix_cnt_d = pix_cnt_q + CW'(1);
                    wv_d      = (row_q >= RW'(ROW_SHIFT - 1)) && (pix_cnt_q >= CW'(ROW_SHIFT - 1));
                end else begin
                    state_d = STREAM;
                end
            end
            ROWSH: begin
                // row_q already counts the finished row, so reaching IMG_HEIGHT ends the frame
                if (row_q < RW'(IMG_HEIGHT)) begin
                    state_d = STREAM;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                pix_cnt_d = {CW{1'b0}};
                col_d     = {CW{1'b0}};
                row_d     = {RW{1'b0}};
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pix_cnt_q <= {CW{1'b0}};
            col_q     <= {CW{1'b0}};
            row_q     <= {RW{1'b0}};
            data_q    <= 8'h00;
            en_q      <= 1'b0;
            shup_q    <= 1'b0;
            wv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            data_q    <= data_d;
            en_q      <= en_d;
            shup_q    <= shup_d;
            wv_q      <= wv_d;
        end
    end

    assign sr_enable       = en_q;
    assign sr_shift_row_up = shup_q;
    assign column_shift_in = data_q;
    assign col_count       = col_q;
    assign row_count       = row_q;
    assign window_valid    = wv_q;
    assign busy            = (state_q != IDLE);
    assign frame_done      = (state_q == DONE);

endmodule

// File: tb/tb_ram_sr_feeder.sv
// Randomized/directed bench for ram_sr_feeder against a pixel-count reference model.
module tb_ram_sr_feeder;

    localparam int W  = 4;
    localparam int H  = 5;
    localparam int RS = 3;

    logic       clock = 1'b0;
    logic       reset, start, pixel_valid, out_ready;
    logic [7:0] pixel_in;
    logic       pixel_ready, sr_enable, sr_shift_row_up, window_valid, busy, frame_done;
    logic [7:0] column_shift_in;
    logic [2:0] col_count;
    logic [2:0] row_count;

    int checks = 0;
    int errors = 0;

    // reference model: frame progress expressed as pixel and row-shift totals
    bit       m_on, m_cool, m_done, m_en, m_shup, m_wv;
    int       m_n, m_sh, m_col;
    logic [7:0] m_data;
    int       pushes, shifts_seen, fd_seen;

    always #5 clock = ~clock;

    ram_sr_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ROW_SHIFT(RS)) dut (
        .clock(clock), .reset(reset), .start(start), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .out_ready(out_ready),
        .sr_enable(sr_enable), .sr_shift_row_up(sr_shift_row_up),
        .column_shift_in(column_shift_in), .col_count(col_count), .row_count(row_count),
        .window_valid(window_valid), .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_on = 0; m_cool = 0; m_done = 0; m_n = 0; m_sh = 0; m_col = 0;
        m_data = 8'h00; m_en = 0; m_shup = 0; m_wv = 0;
    endtask

    // one clock: drive inputs, check ready, advance model, check registered outputs
    task automatic cyc(input logic s, input logic v, input logic [7:0] p, input logic o, input logic r);
        logic exp_ready;
        start = s; pixel_valid = v; pixel_in = p; out_ready = o; reset = r;
        #1;
        exp_ready = m_on && !m_done && !m_cool && (m_n < (m_sh + 1) * W) && o;
        chk("pixel_ready", pixel_ready, exp_ready);
        if (r) begin
            model_clear();
        end else begin
            m_en = 0; m_shup = 0; m_wv = 0;
            if (!m_on) begin
                if (s) m_on = 1;
            end else if (m_done) begin
                m_on = 0; m_done = 0; m_n = 0; m_sh = 0; m_col = 0;
            end else if (m_cool) begin
                m_cool = 0;
                if (m_sh == H) m_done = 1;
            end else if (m_n == (m_sh + 1) * W) begin
                if (o) begin
                    m_en = 1; m_shup = 1; m_sh++; m_col = 0; m_cool = 1;
                end
            end else if (v && o) begin
                m_en = 1; m_data = p; m_col = m_n % W;
                m_wv = ((m_n / W) >= RS - 1) && ((m_n % W) >= RS - 1);
                m_n++;
            end
        end
        @(posedge clock);
        #1;
        chk("sr_enable", sr_enable, m_en);
        chk("sr_shift_row_up", sr_shift_row_up, m_shup);
        chk("column_shift_in", column_shift_in, m_data);
        chk("col_count", col_count, m_col);
        chk("row_count", row_count, m_sh);
        chk("window_valid", window_valid, m_wv);
        chk("busy", busy, m_on);
        chk("frame_done", frame_done, m_done);
        if (sr_enable === 1'b1 && sr_shift_row_up === 1'b0) pushes++;
        if (sr_shift_row_up === 1'b1) shifts_seen++;
        if (frame_done === 1'b1) fd_seen++;
    endtask

    // stream until the model reports the frame over, with a cycle budget
    task automatic finish_frame(input int valid_pct, input int stall_pct, input bit noisy_start, input bit seq_pix);
        int budget;
        budget = 0;
        while (m_on && budget < 400) begin
            cyc(noisy_start ? 1'($urandom_range(0, 1)) : 1'b0,
                1'($urandom_range(0, 99) < valid_pct),
                seq_pix ? 8'(m_n) : 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 99) >= stall_pct), 1'b0);
            budget++;
        end
        chk("frame_within_budget", busy, 1'b0);
    endtask

    task automatic tally_clear();
        pushes = 0; shifts_seen = 0; fd_seen = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_in = 8'h00; out_ready = 1'b1;
        model_clear();
        tally_clear();
        @(posedge clock);
        #1;
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // reset mid-frame drops everything, then a fresh start begins at row 0
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
        chk("reset_midframe_busy", busy, 1'b0);
        chk("reset_midframe_row", row_count, 3'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        finish_frame(100, 0, 1'b0, 1'b1);

        // back-to-back sequential pixels: pushes 00..03 then a row shift
        tally_clear();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        finish_frame(100, 0, 1'b0, 1'b1);
        chk("seq_pushes", pushes, W * H);
        chk("seq_shifts", shifts_seen, H);
        chk("seq_frame_done", fd_seen, 1);

        // mid-row stall of four cycles with valid held high
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        while (m_n < W + 1) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        finish_frame(100, 0, 1'b0, 1'b0);

        // random valid gaps, stray start pulses while busy
        tally_clear();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        finish_frame(60, 0, 1'b1, 1'b0);
        chk("gap_pushes", pushes, W * H);
        chk("gap_shifts", shifts_seen, H);
        chk("gap_frame_done", fd_seen, 1);

        // last pixel accepted as out_ready drops: row shift and frame_done deferred
        tally_clear();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        while (m_n < W * H - 1) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("deferred_no_done", fd_seen, 0);
        chk("deferred_shifts", shifts_seen, H - 1);
        finish_frame(100, 0, 1'b0, 1'b0);
        chk("deferred_done", fd_seen, 1);

        // random stalls and gaps together
        for (int f = 0; f < 3; f++) begin
            tally_clear();
            cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            finish_frame(70, 30, 1'b1, 1'b0);
            chk("rand_pushes", pushes, W * H);
            chk("rand_frame_done", fd_seen, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
